// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled compare timer with one-shot / periodic modes.
// A host starts and stops it; out_tick pulses once per completed period.
module timer_ctrl #(
    parameter int unsigned num_ctrbits   = 16,
    parameter int unsigned num_prescbits = 8
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_start,
    input  logic                     in_stop,
    input  logic                     in_mode,
    input  logic [num_prescbits-1:0] in_presc,
    input  logic [num_ctrbits-1:0]   in_limit,
    output logic [num_ctrbits-1:0]   out_ctr,
    output logic                     out_tick,
    output logic                     out_ready,
    output logic                     out_busy,
    output logic                     out_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [num_ctrbits-1:0]   ctr_q, ctr_d;
    logic [num_prescbits-1:0] presc_ctr_q, presc_ctr_d;
    logic                     mode_q, mode_d;
    logic [num_prescbits-1:0] presc_q, presc_d;
    logic [num_ctrbits-1:0]   limit_q, limit_d;
    logic                     tick_q, tick_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        presc_ctr_d = presc_ctr_q;
        mode_d      = mode_q;
        presc_d     = presc_q;
        limit_d     = limit_q;
        tick_d      = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Stop beats start, so a simultaneous request lands in IDLE.
                if (in_stop) begin
                    state_d = ST_IDLE;
                end else if (in_start) begin
                    mode_d      = in_mode;
                    presc_d     = in_presc;
                    limit_d     = in_limit;
                    ctr_d       = '0;
                    presc_ctr_d = '0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stop freezes the counters and suppresses any coincident tick.
                if (in_stop) begin
                    state_d = ST_IDLE;
                end else if (presc_ctr_q == presc_q) begin
                    presc_ctr_d = '0;
                    if (ctr_q == limit_q) begin
                        tick_d = 1'b1;
                        if (mode_q) begin
                            ctr_d = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        ctr_d = ctr_q + num_ctrbits'(1);
                    end
                end else begin
                    presc_ctr_d = presc_ctr_q + num_prescbits'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d != ST_RUN);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            presc_ctr_q <= '0;
            mode_q      <= 1'b0;
            presc_q     <= '0;
            limit_q     <= '0;
            tick_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            presc_ctr_q <= presc_ctr_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            limit_q     <= limit_d;
            tick_q      <= tick_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_ctr   = ctr_q;
    assign out_tick  = tick_q;
    assign out_ready = ready_q;
    assign out_busy  = busy_q;
    assign out_done  = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: 16-bit default instance plus a 4-bit instance.
module tb_timer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, stop, mode;
    logic [7:0]  presc;
    logic [15:0] limit;
    logic [15:0] ctr;
    logic        tick, ready, busy, done;

    logic        s4_start, s4_stop, s4_mode;
    logic [7:0]  s4_presc;
    logic [3:0]  s4_limit;
    logic [3:0]  ctr4;
    logic        tick4, ready4, busy4, done4;

    int n_cmp;
    int n_err;

    timer_ctrl dut (
        .in_clk(clk), .in_rst(rst_n), .in_start(start), .in_stop(stop),
        .in_mode(mode), .in_presc(presc), .in_limit(limit),
        .out_ctr(ctr), .out_tick(tick), .out_ready(ready),
        .out_busy(busy), .out_done(done)
    );

    timer_ctrl #(.num_ctrbits(4), .num_prescbits(8)) dut4 (
        .in_clk(clk), .in_rst(rst_n), .in_start(s4_start), .in_stop(s4_stop),
        .in_mode(s4_mode), .in_presc(s4_presc), .in_limit(s4_limit),
        .out_ctr(ctr4), .out_tick(tick4), .out_ready(ready4),
        .out_busy(busy4), .out_done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs then reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge with the given configuration.
    task automatic do_start(input logic m, input logic [7:0] p, input logic [15:0] l);
        mode  = m;
        presc = p;
        limit = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ctr, tick, ready, busy, done} !== {16'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_init: got ctr=%0d tick=%b rdy=%b busy=%b done=%b, want 0 0 1 0 0",
                     ctr, tick, ready, busy, done);
        end
        // Run to ctr=5 then reset asynchronously mid-cycle.
        do_start(1'b1, 8'd0, 16'd9);
        repeat (5) step();
        n_cmp++;
        if (ctr !== 16'd5) begin
            n_err++;
            $display("FAIL reset_pre: got ctr=%0d want 5", ctr);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ctr, tick, ready, busy, done} !== {16'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_async: got ctr=%0d tick=%b rdy=%b busy=%b done=%b, want 0 0 1 0 0",
                     ctr, tick, ready, busy, done);
        end
        #1;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({ctr, busy} !== {16'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_idle: got ctr=%0d busy=%b want 0 0", ctr, busy);
        end
    endtask

    task automatic test_periodic();
        logic [15:0] exp_ctr;
        do_start(1'b1, 8'd0, 16'd3);
        n_cmp++;
        if ({ctr, busy, ready} !== {16'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL per_start: got ctr=%0d busy=%b rdy=%b want 0 1 0", ctr, busy, ready);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_ctr = 16'(i % 4);
            n_cmp++;
            if ({ctr, tick, busy} !== {exp_ctr, (i % 4) == 0, 1'b1}) begin
                n_err++;
                $display("FAIL per_seq[%0d]: got ctr=%0d tick=%b busy=%b want %0d %b 1",
                         i, ctr, tick, busy, exp_ctr, (i % 4) == 0);
            end
        end
        do_stop();
    endtask

    task automatic test_oneshot();
        logic [15:0] exp_ctr;
        do_start(1'b0, 8'd2, 16'd2);
        for (int i = 1; i <= 9; i++) begin
            step();
            exp_ctr = (i == 9) ? 16'd2 : 16'(i / 3);
            n_cmp++;
            if ({ctr, tick} !== {exp_ctr, i == 9}) begin
                n_err++;
                $display("FAIL os_seq[%0d]: got ctr=%0d tick=%b want %0d %b",
                         i, ctr, tick, exp_ctr, i == 9);
            end
        end
        n_cmp++;
        if ({done, ready, busy} !== 3'b110) begin
            n_err++;
            $display("FAIL os_done: got done=%b rdy=%b busy=%b want 1 1 0", done, ready, busy);
        end
        repeat (4) step();
        n_cmp++;
        if ({ctr, tick, done} !== {16'd2, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL os_hold: got ctr=%0d tick=%b done=%b want 2 0 1", ctr, tick, done);
        end
        do_start(1'b0, 8'd2, 16'd2);
        n_cmp++;
        if ({ctr, busy, done} !== {16'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL os_restart: got ctr=%0d busy=%b done=%b want 0 1 0", ctr, busy, done);
        end
        do_stop();
    endtask

    task automatic test_stop_priority();
        do_start(1'b1, 8'd0, 16'd4);
        repeat (4) step();
        n_cmp++;
        if (ctr !== 16'd4) begin
            n_err++;
            $display("FAIL stop_pre: got ctr=%0d want 4", ctr);
        end
        do_stop();
        n_cmp++;
        if ({ctr, tick, busy, ready} !== {16'd4, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL stop_wins: got ctr=%0d tick=%b busy=%b rdy=%b want 4 0 0 1",
                     ctr, tick, busy, ready);
        end
        start = 1'b1;
        stop  = 1'b1;
        step();
        step();
        start = 1'b0;
        stop  = 1'b0;
        n_cmp++;
        if ({ctr, busy, ready} !== {16'd4, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL start_stop_both: got ctr=%0d busy=%b rdy=%b want 4 0 1", ctr, busy, ready);
        end
    endtask

    task automatic test_latching();
        do_start(1'b1, 8'd0, 16'd3);
        limit = 16'd7;
        presc = 8'd2;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++;
            if ({ctr, tick} !== {16'(i % 4), (i % 4) == 0}) begin
                n_err++;
                $display("FAIL latch_old[%0d]: got ctr=%0d tick=%b want %0d %b",
                         i, ctr, tick, i % 4, (i % 4) == 0);
            end
        end
        do_stop();
        do_start(1'b1, 8'd0, 16'd7);
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++;
            if ({ctr, tick} !== {16'(i % 8), i == 8}) begin
                n_err++;
                $display("FAIL latch_new[%0d]: got ctr=%0d tick=%b want %0d %b",
                         i, ctr, tick, i % 8, i == 8);
            end
        end
        do_stop();
    endtask

    task automatic test_limit_zero();
        do_start(1'b1, 8'd1, 16'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
            n_cmp++;
            if ({ctr, tick, busy} !== {16'd0, (i % 2) == 0, 1'b1}) begin
                n_err++;
                $display("FAIL l0[%0d]: got ctr=%0d tick=%b busy=%b want 0 %b 1",
                         i, ctr, tick, busy, (i % 2) == 0);
            end
        end
        do_stop();
    endtask

    task automatic test_max_limit();
        s4_mode  = 1'b1;
        s4_presc = 8'd0;
        s4_limit = 4'd15;
        s4_start = 1'b1;
        step();
        s4_start = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            step();
            n_cmp++;
            if ({ctr4, tick4, busy4} !== {4'(i % 16), (i % 16) == 0, 1'b1}) begin
                n_err++;
                $display("FAIL max4[%0d]: got ctr=%0d tick=%b busy=%b want %0d %b 1",
                         i, ctr4, tick4, busy4, i % 16, (i % 16) == 0);
            end
        end
        s4_stop = 1'b1;
        step();
        s4_stop = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; mode = 1'b0; presc = '0; limit = '0;
        s4_start = 1'b0; s4_stop = 1'b0; s4_mode = 1'b0; s4_presc = '0; s4_limit = '0;
        #12;
        rst_n = 1'b1;
        step();
        test_reset();
        test_periodic();
        test_oneshot();
        test_stop_priority();
        test_latching();
        test_limit_zero();
        test_max_limit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
